// File: rtl/sram_req_ctrl.sv
// Single-outstanding request controller that drives an OpenRAM-style single-port SRAM macro.
// Byte-addressed valid/ready requests become one registered SRAM strobe and one registered response.
module sram_req_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [3:0]            sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t     state, state_nxt;
  logic       we_q;
  logic [3:0] cnt;
  logic       accept;
  logic       addr_err;

  assign accept   = req_valid_i && (state == IDLE);
  // Misaligned byte addresses and anything beyond the macro's word range are rejected.
  assign addr_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (ADDR_WIDTH + 2)) != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept) state_nxt = addr_err ? RESP : ISSUE;
      end
      ISSUE: state_nxt = we_q ? RESP : WAIT;
      WAIT:  if (cnt == 4'd1) state_nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pins return to their idle values every cycle unless a strobe is being launched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= 4'd0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      we_q         <= 1'b0;
      cnt          <= 4'd0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
    end else begin
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= 4'd0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q <= req_we_i;
            if (addr_err) begin
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              sram_csb_o   <= 1'b0;
              sram_web_o   <= ~req_we_i;
              sram_wmask_o <= req_we_i ? req_be_i : 4'd0;
              sram_addr_o  <= req_addr_i[ADDR_WIDTH+1:2];
              sram_wdata_o <= req_we_i ? req_wdata_i : '0;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end else begin
            cnt <= LAT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) rsp_rdata_o <= sram_rdata_i;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Initiator side of the OpenRAM-style single-port SRAM macro interface: csb and web active-low, 4-bit byte wmask, word address, din/dout.
- Accepts byte-addressed valid/ready requests from the core memory stage and drives one SRAM access per request.
- Waits a fixed read latency, then returns a registered response with rdata or an error.
- Sits between the core data/instruction port and the SRAM wrapper instance.

Parameters:
- DATA_WIDTH, 32: data bus width. Fixed at 32 because wmask is 4 bits.
- ADDR_WIDTH, 12: SRAM word-address width.
- READ_LATENCY, 1: cycles from the strobe cycle until sram_rdata_i is valid. Legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_be_i  in  4  byte enables for writes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  request was rejected; no SRAM access was made.
- sram_csb_o  out  1  chip select, active-low.
- sram_web_o  out  1  write enable, active-low (0 = write).
- sram_wmask_o  out  4  byte write mask.
- sram_addr_o  out  ADDR_WIDTH  word address.
- sram_wdata_o  out  DATA_WIDTH  write data to SRAM din.
- sram_rdata_i  in  DATA_WIDTH  read data from SRAM dout.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_wdata_o=0, latency counter=0.
  - Reset mid-operation abandons any in-flight access and any pending response; no response is produced for it.
- All SRAM-side outputs are registered. Outside ISSUE they hold the reset values above.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1; req_ready_o is 0 in every other state.
  - On req_valid_i && req_ready_o, capture the request.
  - Error check: req_addr_i[1:0]!=0, or req_addr_i[31:ADDR_WIDTH+2]!=0. On error go to RESP with rsp_err_o=1 and rsp_rdata_o=0; SRAM outputs stay idle.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - sram_csb_o=0, sram_addr_o=req_addr_i[ADDR_WIDTH+1:2].
  - Write: sram_web_o=0, sram_wmask_o=req_be_i, sram_wdata_o=req_wdata_i; next state RESP with rsp_err_o=0, rsp_rdata_o=0.
  - Read: sram_web_o=1, sram_wmask_o=0, sram_wdata_o=0; load counter with READ_LATENCY; next state WAIT.
  - A write with req_be_i=0 is still issued (no bytes change) and is not an error.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter==1, sram_rdata_i is sampled into rsp_rdata_o at the closing edge; next state RESP.
  - WAIT therefore lasts exactly READ_LATENCY cycles.
- RESP:
  - rsp_valid_o=1, with rsp_rdata_o and rsp_err_o held stable until rsp_ready_i=1.
  - On handshake: rsp_valid_o=0 next cycle, rsp_err_o and rsp_rdata_o cleared to 0, return to IDLE.
  - rsp_ready_i already high when rsp_valid_o rises completes the handshake in that first RESP cycle.
- Latency, with acceptance in cycle T:
  - Strobe visible in T+1.
  - Write: rsp_valid_o in T+2.
  - Read: rsp_valid_o in T+2+READ_LATENCY.
  - Error: rsp_valid_o in T+1.
- Throughput: at most one outstanding request; no pipelining.
- rsp_ready_i is ignored outside RESP.
- Request inputs are ignored while req_ready_o=0.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> sram_csb_o=1, sram_web_o=1, req_ready_o=1, rsp_valid_o=0 immediately, before any clock edge.
- Write then read:
  - Write addr 0x0000_0010, wdata 0xDEADBEEF, be 0xF in cycle T -> in T+1 only: csb=0, web=0, addr=0x004, wmask=0xF; rsp_valid in T+2 with err=0.
  - Read of the same address with READ_LATENCY=3 and the SRAM model returning 0xDEADBEEF -> rsp_rdata_o=0xDEADBEEF at T+5.
- Partial write: be=0x3 to 0x0000_0020 -> sram_wmask_o=0x3 and sram_addr_o=0x008 for one cycle.
- Errors, each -> rsp_valid in T+1 with err=1, rdata=0, and sram_csb_o never 0:
  - Read of 0x0000_0002 (misaligned).
  - Read of 0x0000_4000 (out of range for ADDR_WIDTH=12).
- Backpressure: rsp_ready_i held 0 for 5 cycles after a read response -> rsp_valid_o and rsp_rdata_o stable throughout, req_ready_o=0; after rsp_ready_i=1, req_ready_o=1 on the next cycle.
- Reset in WAIT: rst_i pulsed during a READ_LATENCY=3 read -> no response is produced; the next request completes normally.
